// File: rtl/bti_arb_mux.sv
// N-master to 1-slave BTI arbiter/multiplexer with a combinational request path
// and an ordering FIFO that routes in-order slave responses back by master index.
module bti_arb_mux #(
    parameter int N_MST    = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_OUTS = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MST-1:0]              mst_req_vld,
    output logic [N_MST-1:0]              mst_req_rdy,
    input  logic [N_MST*AW-1:0]           mst_req_addr,
    input  logic [N_MST-1:0]              mst_req_wr,
    input  logic [N_MST*DW-1:0]           mst_req_wdata,
    input  logic [N_MST*DW/8-1:0]         mst_req_wstrb,
    output logic [N_MST-1:0]              mst_rsp_vld,
    input  logic [N_MST-1:0]              mst_rsp_rdy,
    output logic [DW-1:0]                 mst_rsp_rdata,
    output logic                          slv_req_vld,
    input  logic                          slv_req_rdy,
    output logic [AW-1:0]                 slv_req_addr,
    output logic                          slv_req_wr,
    output logic [DW-1:0]                 slv_req_wdata,
    output logic [DW/8-1:0]               slv_req_wstrb,
    input  logic                          slv_rsp_vld,
    output logic                          slv_rsp_rdy,
    input  logic [DW-1:0]                 slv_rsp_rdata,
    output logic [$clog2(MAX_OUTS+1)-1:0] outs_cnt,
    output logic                          stray_rsp
);

    localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int PW = $clog2(MAX_OUTS);
    localparam int CW = $clog2(MAX_OUTS + 1);
    localparam int SW = DW / 8;

    logic [IW-1:0] r_ptr;
    logic          r_lock;
    logic [IW-1:0] r_lock_idx;
    logic [IW-1:0] r_fifo [MAX_OUTS];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_stray;

    logic [IW-1:0] w_gnt_idx;
    logic [IW-1:0] w_head;
    logic          w_any;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_any   = |mst_req_vld;
    assign w_full  = (r_cnt == CW'(MAX_OUTS));
    assign w_empty = (r_cnt == '0);
    assign w_push  = slv_req_vld && slv_req_rdy;
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_pop   = slv_rsp_vld && slv_rsp_rdy && !w_empty;

    assign slv_req_vld   = w_any && !w_full;
    assign mst_rsp_rdata = slv_rsp_rdata;
    assign outs_cnt      = r_cnt;
    assign stray_rsp     = r_stray;

    // Loops run from the top index down so the lowest search position wins;
    // a registered lock overrides the search until the stalled transfer completes.
    always_comb begin
        int j;
        j         = 0;
        w_gnt_idx = '0;
        if (r_lock) begin
            w_gnt_idx = r_lock_idx;
        end else if (ARB_MODE == 1) begin
            for (int i = N_MST - 1; i >= 0; i--) begin
                if (mst_req_vld[i]) w_gnt_idx = IW'(i);
            end
        end else begin
            for (int k = N_MST - 1; k >= 0; k--) begin
                j = int'(r_ptr) + k;
                if (j >= N_MST) j = j - N_MST;
                if (mst_req_vld[j]) w_gnt_idx = IW'(j);
            end
        end
    end

    always_comb begin
        mst_req_rdy   = '0;
        slv_req_addr  = mst_req_addr[AW-1:0];
        slv_req_wr    = mst_req_wr[0];
        slv_req_wdata = mst_req_wdata[DW-1:0];
        slv_req_wstrb = mst_req_wstrb[SW-1:0];
        for (int i = 0; i < N_MST; i++) begin
            if (w_gnt_idx == IW'(i)) begin
                mst_req_rdy[i] = w_push;
                slv_req_addr   = mst_req_addr[i*AW +: AW];
                slv_req_wr     = mst_req_wr[i];
                slv_req_wdata  = mst_req_wdata[i*DW +: DW];
                slv_req_wstrb  = mst_req_wstrb[i*SW +: SW];
            end
        end
    end

    // With nothing outstanding the response is swallowed so a stray beat cannot wedge the slave.
    always_comb begin
        mst_rsp_vld = '0;
        slv_rsp_rdy = 1'b1;
        if (!w_empty) begin
            for (int i = 0; i < N_MST; i++) begin
                if (w_head == IW'(i)) begin
                    mst_rsp_vld[i] = slv_rsp_vld;
                    slv_rsp_rdy    = mst_rsp_rdy[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_stray    <= 1'b0;
        end else begin
            if (slv_req_vld && !slv_req_rdy) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_gnt_idx;
            end else if (w_push) begin
                r_lock <= 1'b0;
            end
            if (w_push && (ARB_MODE == 0)) begin
                r_ptr <= (w_gnt_idx == IW'(N_MST - 1)) ? '0 : w_gnt_idx + IW'(1);
            end
            if (w_empty && slv_rsp_vld) r_stray <= 1'b1;
        end
    end

endmodule
